// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: (a*b) mod m, interleaved shift/add/subtract.
// Optional operand range checking is enabled by defining MODMUL_RANGE_CHECK_EN.
module mod_mul_seq #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] m_i,
    output logic         ready_o,
    output logic         valid_o,
    input  logic         ack_i,
    output logic [N-1:0] result_o,
    output logic         zero_o,
    output logic         error_o
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_m;
    logic [N:0]    r_R;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_result;
    logic          r_zero;

    logic [N:0]    w_m_ext;
    logic [N:0]    w_a_ext;
    logic [N:0]    w_t1;
    logic [N:0]    w_t2;
    logic [N:0]    w_t3;
    logic [N:0]    w_t4;
    logic [N-1:0]  w_res;
    logic          w_accept;
    logic          w_last;

    assign w_m_ext  = {1'b0, r_m};
    assign w_a_ext  = {1'b0, r_a};
    assign w_accept = (r_state == IDLE) && start_i;
    assign w_last   = (r_cnt == '0);

    // One iteration of the interleaved reduction for bit b[cnt]
    always_comb begin
        w_t1 = r_R << 1;
        w_t2 = (w_t1 >= w_m_ext) ? (w_t1 - w_m_ext) : w_t1;
        w_t3 = r_b[r_cnt] ? (w_t2 + w_a_ext) : w_t2;
        w_t4 = (w_t3 >= w_m_ext) ? (w_t3 - w_m_ext) : w_t3;
        // m of 0 or 1 always yields a zero residue
        w_res = (r_m <= N'(1)) ? '0 : w_t4[N-1:0];
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start_i) w_next = CALC;
            CALC:    if (w_last) w_next = DONE;
            DONE:    if (ack_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result latching
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_R      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= a_i;
                r_b   <= b_i;
                r_m   <= m_i;
                r_R   <= '0;
                r_cnt <= CW'(N - 1);
            end else if (r_state == CALC) begin
                r_R <= w_t4;
                if (w_last) begin
                    r_result <= w_res;
                    r_zero   <= (w_res == '0);
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

`ifdef MODMUL_RANGE_CHECK_EN
    logic r_err;
    logic w_range_err;

    assign w_range_err = (a_i >= m_i) || (b_i >= m_i) || (m_i == '0);

    // Range flag: captured at accept, dropped when the result is taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_range_err;
        end else if ((r_state == DONE) && ack_i) begin
            r_err <= 1'b0;
        end
    end
`endif

    // Handshake and result outputs
    always_comb begin
        ready_o  = (r_state == IDLE);
        valid_o  = (r_state == DONE);
        result_o = r_result;
        zero_o   = r_zero;
`ifdef MODMUL_RANGE_CHECK_EN
        error_o  = r_err && (r_state == DONE);
`else
        error_o  = 1'b0;
`endif
    end

endmodule

// File: doc/mod_mul_seq.md
Name: mod_mul_seq

Overview:
- Multi-cycle sequential modular multiplier for the RSA pipeline; computes (a*b) mod m with the interleaved shift/add/conditional-subtract method, MSB of b first.
- Acts as the issuing side of the ALU interface: it generates the add and subtract steps the ALU would otherwise be asked for and consumes its own compare/zero results internally.
- Sits beside the ALU in the EX stage as a long-latency functional unit. It uses a start/ready request and a valid/ack result handshake so the pipeline can stall around it.

Parameters:
- N, 4, operand/modulus/result width in bits (N >= 2).

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request; accepted only when ready_o=1.
- a_i  in  N  multiplicand.
- b_i  in  N  multiplier.
- m_i  in  N  modulus.
- ready_o  out  1  unit idle, can accept start_i.
- valid_o  out  1  result_o/zero_o valid.
- ack_i  in  1  consumer takes result; meaningful only while valid_o=1.
- result_o  out  N  (a*b) mod m.
- zero_o  out  1  result_o == 0 (same semantics as the ALU ZeroFlag).
- error_o  out  1  operand range error (see Optional Feature).

Behaviour:
- One clock; reset is asynchronous and active-low: rst_ni low forces state IDLE immediately, regardless of clk_i.
- Reset values: ready_o=1, valid_o=0, result_o=0, zero_o=0, error_o=0, internal R=0, counter=0.
- FSM states IDLE, CALC, DONE.
- IDLE: ready_o=1.
  - On an edge with start_i=1: latch a, b, m; R=0; cnt=N-1; go to CALC.
- CALC: ready_o=0. Each edge processes bit b[cnt] on an (N+1)-bit R:
  - T = 2R; if T >= m then T = T - m.
  - If b[cnt] then T = T + a; if T >= m then T = T - m.
  - R = T. If cnt == 0, go to DONE; else cnt = cnt - 1.
- DONE: valid_o=1, result_o=R[N-1:0], zero_o=(result_o==0).
  - Outputs hold stable until an edge with ack_i=1, then go to IDLE (valid_o=0, ready_o=1).
  - result_o and zero_o keep their last value in IDLE.
- Latency: valid_o rises exactly N edges after the accepting edge. Throughput is one operation per N+2 cycles minimum (accept, N calc, ack).
- Width rule: with a < m, all intermediate values are < 2m < 2^(N+1), so N+1 bits need no overflow handling.
- start_i while not in IDLE is ignored (not queued). ack_i outside DONE is ignored.
- Back-to-back: ack in DONE and start in the following IDLE cycle are both honoured. There is no same-cycle ack+start.
- Operand changes on a_i/b_i/m_i after the accepting edge have no effect.
- m == 0: the FSM runs with normal latency; result_o forced to 0, zero_o=1.
- m == 1: result_o=0, zero_o=1.
- Reset asserted mid-CALC or in DONE aborts the operation: no valid_o, outputs return to reset values.

Optional Feature:
- Macro MODMUL_RANGE_CHECK_EN.
- Defined: at the accepting edge the unit checks a >= m, b >= m, or m == 0. If any is true, error_o=1 is latched. The operation still completes normally with m==0 forcing result 0. error_o is valid alongside valid_o and clears on ack.
- Not defined: error_o tied to 0, no comparators built. Keeping a, b < m is the issuer's responsibility; for a >= m, result_o equals the algorithm's output truncated to N bits.

Test Plan:
- Reset: assert rst_ni=0 mid-CALC -> ready_o=1, valid_o=0, result_o=0 immediately (asynchronously); no spurious valid_o after release.
- N=8: a=7, b=9, m=11, start -> valid_o exactly 8 edges later, result_o=8, zero_o=0; hold ack_i=0 for 5 cycles -> outputs stable.
- N=8: a=250, b=250, m=251 -> result_o=1. Then ack and start next cycle with a=10, b=10, m=11 -> result_o=1, second valid_o 8 edges after second accept.
- N=8: a=0, b=200, m=201 -> result_o=0, zero_o=1. Also m=1, a=0, b=0 -> result_o=0, zero_o=1.
- N=8: pulse start_i during CALC with different operands -> ignored, first result (7*9 mod 11=8) unaffected; ack_i pulsed in IDLE -> no effect.
- MODMUL_RANGE_CHECK_EN defined, N=8: a=12, b=3, m=11 -> error_o=1 with valid_o; m=0 -> error_o=1, result_o=0. Macro undefined: same stimulus -> error_o=0.
